// File: rtl/mul_div_sequencer_pkg.sv
// rtl/mul_div_sequencer_pkg.sv - function codes, FSM states and op-kind helpers for the HI/LO sequencer
// Divide support is selected by MULDIV_DIV_EN in the files that import these packages.
package libFunctions;
  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;
endpackage

package libMulDiv;
  import libFunctions::*;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_kind_e;

  function automatic logic func_is_signed(input logic [5:0] f);
    return (f == FUNC_MULT) || (f == FUNC_DIV);
  endfunction

  function automatic op_kind_e func_kind(input logic [5:0] f);
    return ((f == FUNC_DIV) || (f == FUNC_DIVU)) ? OP_DIV : OP_MUL;
  endfunction
endpackage

// File: rtl/mul_div_sequencer_step.sv
// rtl/mul_div_sequencer_step.sv - one combinational shift-add / restoring-divide iteration (MULDIV_DIV_EN adds divide)
// acc holds {upper, lower}: product/multiplier for multiply, remainder/quotient for divide.
module mulDivStep
  import libMulDiv::*;
#(
  parameter int WIDTH = 32
) (
  input  op_kind_e             kind_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     operand_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic                 q_bit_o
);

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  assign mul_sum  = acc_i[0] ? ({1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, operand_i})
                             : {1'b0, acc_i[2*WIDTH-1:WIDTH]};
  assign mul_next = {mul_sum, acc_i[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       trial;
  logic                 fits;
  logic [2*WIDTH-1:0]   div_next;

  // Remainder stays below the divisor, so the trial difference always fits in WIDTH+1 bits signed.
  assign rem_shift = acc_i[2*WIDTH-1:WIDTH-1];
  assign trial     = rem_shift - {1'b0, operand_i};
  assign fits      = ~trial[WIDTH];
  assign div_next  = {(fits ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0};

  always_comb begin
    acc_o   = mul_next;
    q_bit_o = 1'b0;
    if (kind_i == OP_DIV) begin
      acc_o   = div_next;
      q_bit_o = fits;
    end
  end
`else
  logic unused_kind;

  assign unused_kind = kind_i;
  assign acc_o       = mul_next;
  assign q_bit_o     = 1'b0;
`endif

endmodule

// File: rtl/mul_div_sequencer.sv
// rtl/mul_div_sequencer.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO registers
// MULDIV_DIV_EN compiles in the divide path and divZero; otherwise only multiply is accepted.
module mul_div_sequencer
  import libFunctions::*;
  import libMulDiv::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e               state_q, state_d;
  logic [5:0]           func_q, func_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 res_neg_q, res_neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 func_legal;
  logic                 op_signed;
  op_kind_e             kind;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   step_acc;
  logic                 step_q;
  logic [2*WIDTH-1:0]   prod_fix;

`ifdef MULDIV_DIV_EN
  logic                 rem_neg_q, rem_neg_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     quot_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign func_legal = (func == FUNC_MULT) || (func == FUNC_MULTU) ||
                      (func == FUNC_DIV)  || (func == FUNC_DIVU);
  assign quot_fix   = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix    = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign divZero    = (state_q == S_DONE) && dz_q;
`else
  assign func_legal = (func == FUNC_MULT) || (func == FUNC_MULTU);
  assign divZero    = 1'b0;
`endif

  assign op_signed = func_is_signed(func_q);
  assign kind      = func_kind(func_q);
  assign a_mag     = (op_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag     = (op_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  assign prod_fix  = res_neg_q ? -acc_q : acc_q;

  mulDivStep #(.WIDTH(WIDTH)) u_step (
    .kind_i    (kind),
    .acc_i     (acc_q),
    .operand_i (m_q),
    .acc_o     (step_acc),
    .q_bit_o   (step_q)
  );

  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_neg_d = res_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MULDIV_DIV_EN
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && func_legal) begin
          func_d  = func;
          a_d     = operandA;
          b_d     = operandB;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        // Magnitudes in, signs remembered; the lower half doubles as multiplier / dividend.
        acc_d     = {{WIDTH{1'b0}}, a_mag};
        m_d       = b_mag;
        res_neg_d = op_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
`ifdef MULDIV_DIV_EN
        rem_neg_d = op_signed && a_q[WIDTH-1];
`endif
        cnt_d     = CW'(WIDTH - 1);
        state_d   = S_RUN;
      end
      S_RUN: begin
        acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        hi_d    = prod_fix[2*WIDTH-1:WIDTH];
        lo_d    = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        dz_d    = 1'b0;
        if (kind == OP_DIV) begin
          if (b_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
`endif
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      func_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_DIV_EN
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      res_neg_q <= res_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULDIV_DIV_EN
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
`endif
    end
  end

  assign busy = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb/tb_mul_div_sequencer.sv - self-checking bench for mul_div_sequencer (divide cases follow MULDIV_DIV_EN)
module tb_mul_div_sequencer;

  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam int         LAT     = 35;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  func = 6'h0;
  logic [31:0] operandA = 32'h0;
  logic [31:0] operandB = 32'h0;
  logic        busy, done, divZero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  mul_div_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .func     (func),
    .operandA (operandA),
    .operandB (operandB),
    .busy     (busy),
    .done     (done),
    .divZero  (divZero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero like MIPS.
  function automatic void ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    p  = 64'h0;
    case (f)
      F_MULTU: p = {32'h0, a} * {32'h0, b};
      F_MULT:  p = 64'(sa * sb);
      F_DIVU, F_DIV: begin
        if (b == 32'h0) begin
          dz = 1'b1;
          p  = {a, 32'hFFFF_FFFF};
        end else if (f == F_DIVU) begin
          p = {a % b, a / b};
        end else begin
          p = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      default: p = 64'h0;
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  task automatic drive_start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    func     = f;
    operandA = a;
    operandB = b;
  endtask

  // Waits for done after a start driven at the current negedge; cyc = -1 on timeout.
  task automatic wait_done(output int cyc, output logic [31:0] h, output logic [31:0] l,
                           output logic dz, output logic busy_ok);
    bit got = 0;
    cyc = 0; busy_ok = 1'b1; h = 32'h0; l = 32'h0; dz = 1'b0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        got = 1; h = hi; l = lo; dz = divZero;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      if (cyc == 1) begin
        start = 1'b0; operandA = $urandom; operandB = $urandom;
      end
    end
    if (!got) cyc = -1;
  endtask

  task automatic observe_idle(input int n, output bit saw_busy, output bit saw_done, output bit saw_dz);
    saw_busy = 0; saw_done = 0; saw_dz = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) saw_busy = 1;
      if (done !== 1'b0) saw_done = 1;
      if (divZero !== 1'b0) saw_dz = 1;
      if (i == 0) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 5;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    if (divZero !== 1'b0) begin n_bad++; $display("FAIL reset_divzero got %b want 0", divZero); end
    if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
    if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
    reset = 1'b0;
  endtask

  task automatic test_multu_max();
    int cyc; logic [31:0] h, l; logic dz, bok;
    @(negedge clk);
    drive_start(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, h, l, dz, bok);
    n_cmp += 5;
    if (cyc != LAT) begin n_bad++; $display("FAIL multu_latency got %0d want %0d", cyc, LAT); end
    if (bok !== 1'b1) begin n_bad++; $display("FAIL multu_busy got low want high in cycles 1-34"); end
    if (h !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi got %h want fffffffe", h); end
    if (l !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo got %h want 00000001", l); end
    if (dz !== 1'b0) begin n_bad++; $display("FAIL multu_dz got %b want 0", dz); end
    exp_hi = 32'hFFFF_FFFE; exp_lo = 32'h1;
  endtask

  task automatic test_back_to_back();
    int cyc; logic [31:0] h, l; logic dz, bok;
    @(negedge clk);
    drive_start(F_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(cyc, h, l, dz, bok);
    n_cmp += 3;
    if (cyc != LAT) begin n_bad++; $display("FAIL mult_neg_latency got %0d want %0d", cyc, LAT); end
    if (h !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_neg_hi got %h want ffffffff", h); end
    if (l !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_neg_lo got %h want ffffffeb", l); end
    drive_start(F_MULT, 32'd5, 32'd5);
    wait_done(cyc, h, l, dz, bok);
    n_cmp += 4;
    if (cyc != LAT) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", cyc, LAT); end
    if (bok !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got idle gap want none"); end
    if (h !== 32'h0) begin n_bad++; $display("FAIL b2b_hi got %h want 0", h); end
    if (l !== 32'd25) begin n_bad++; $display("FAIL b2b_lo got %h want 19", l); end
    exp_hi = 32'h0; exp_lo = 32'd25;
  endtask

  task automatic test_div();
`ifdef MULDIV_DIV_EN
    logic [5:0]  tf [5] = '{F_DIV, F_DIVU, F_DIV, F_DIV, F_DIV};
    logic [31:0] ta [5] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] tb [5] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    int cyc; logic [31:0] h, l, eh, el; logic dz, edz, bok;
    for (int i = 0; i < 5; i++) begin
      ref_model(tf[i], ta[i], tb[i], eh, el, edz);
      @(negedge clk);
      drive_start(tf[i], ta[i], tb[i]);
      wait_done(cyc, h, l, dz, bok);
      n_cmp += 4;
      if (cyc != LAT) begin n_bad++; $display("FAIL div%0d_latency got %0d want %0d", i, cyc, LAT); end
      if (h !== eh) begin n_bad++; $display("FAIL div%0d_hi got %h want %h", i, h, eh); end
      if (l !== el) begin n_bad++; $display("FAIL div%0d_lo got %h want %h", i, l, el); end
      if (dz !== edz) begin n_bad++; $display("FAIL div%0d_dz got %b want %b", i, dz, edz); end
      exp_hi = eh; exp_lo = el;
    end
`else
    bit sb, sd, sz;
    logic [5:0] tf [2] = '{F_DIV, F_DIVU};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_start(tf[i], 32'd100, 32'd0);
      observe_idle(40, sb, sd, sz);
      n_cmp += 5;
      if (sb) begin n_bad++; $display("FAIL nodiv%0d_busy got high want low", i); end
      if (sd) begin n_bad++; $display("FAIL nodiv%0d_done got pulse want none", i); end
      if (sz) begin n_bad++; $display("FAIL nodiv%0d_divzero got 1 want 0", i); end
      if (hi !== exp_hi) begin n_bad++; $display("FAIL nodiv%0d_hi got %h want %h", i, hi, exp_hi); end
      if (lo !== exp_lo) begin n_bad++; $display("FAIL nodiv%0d_lo got %h want %h", i, lo, exp_lo); end
    end
`endif
  endtask

  task automatic test_divzero();
`ifdef MULDIV_DIV_EN
    int cyc; logic [31:0] h, l; logic dz, bok;
    @(negedge clk);
    drive_start(F_DIVU, 32'h1234, 32'h0);
    wait_done(cyc, h, l, dz, bok);
    n_cmp += 4;
    if (cyc != LAT) begin n_bad++; $display("FAIL dz_latency got %0d want %0d", cyc, LAT); end
    if (dz !== 1'b1) begin n_bad++; $display("FAIL dz_flag got %b want 1", dz); end
    if (l !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_lo got %h want ffffffff", l); end
    if (h !== 32'h1234) begin n_bad++; $display("FAIL dz_hi got %h want 00001234", h); end
    @(negedge clk);
    n_cmp += 1;
    if (divZero !== 1'b0) begin n_bad++; $display("FAIL dz_pulse_width got %b want 0", divZero); end
    @(negedge clk);
    drive_start(F_DIV, 32'hFFFF_FFFB, 32'h0);
    wait_done(cyc, h, l, dz, bok);
    n_cmp += 3;
    if (dz !== 1'b1) begin n_bad++; $display("FAIL dzs_flag got %b want 1", dz); end
    if (l !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dzs_lo got %h want ffffffff", l); end
    if (h !== 32'hFFFF_FFFB) begin n_bad++; $display("FAIL dzs_hi got %h want fffffffb", h); end
    exp_hi = 32'hFFFF_FFFB; exp_lo = 32'hFFFF_FFFF;
`else
    int cyc; logic [31:0] h, l; logic dz, bok;
    @(negedge clk);
    drive_start(F_MULTU, 32'h1234, 32'h0);
    wait_done(cyc, h, l, dz, bok);
    n_cmp += 3;
    if (dz !== 1'b0) begin n_bad++; $display("FAIL nodiv_dz got %b want 0", dz); end
    if (h !== 32'h0) begin n_bad++; $display("FAIL mul0_hi got %h want 0", h); end
    if (l !== 32'h0) begin n_bad++; $display("FAIL mul0_lo got %h want 0", l); end
    exp_hi = 32'h0; exp_lo = 32'h0;
`endif
  endtask

  task automatic test_illegal();
    bit sb, sd, sz;
    logic [5:0] tf [2] = '{F_ADD, F_MFHI};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_start(tf[i], 32'd9, 32'd9);
      observe_idle(40, sb, sd, sz);
      n_cmp += 5;
      if (sb) begin n_bad++; $display("FAIL illegal%0d_busy got high want low", i); end
      if (sd) begin n_bad++; $display("FAIL illegal%0d_done got pulse want none", i); end
      if (sz) begin n_bad++; $display("FAIL illegal%0d_divzero got 1 want 0", i); end
      if (hi !== exp_hi) begin n_bad++; $display("FAIL illegal%0d_hi got %h want %h", i, hi, exp_hi); end
      if (lo !== exp_lo) begin n_bad++; $display("FAIL illegal%0d_lo got %h want %h", i, lo, exp_lo); end
    end
  endtask

  task automatic test_start_ignored();
    int cyc = 0; bit got = 0; logic [31:0] h = 0, l = 0, eh, el; logic edz;
    ref_model(F_MULTU, 32'h0001_2345, 32'h0006_789A, eh, el, edz);
    @(negedge clk);
    drive_start(F_MULTU, 32'h0001_2345, 32'h0006_789A);
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin got = 1; h = hi; l = lo; end
      if (cyc == 1) start = 1'b0;
      if (cyc == 10) drive_start(F_MULT, 32'hDEAD_BEEF, 32'h0BAD_F00D);
      if (cyc == 11) start = 1'b0;
    end
    if (!got) cyc = -1;
    n_cmp += 3;
    if (cyc != LAT) begin n_bad++; $display("FAIL ignore_latency got %0d want %0d", cyc, LAT); end
    if (h !== eh) begin n_bad++; $display("FAIL ignore_hi got %h want %h", h, eh); end
    if (l !== el) begin n_bad++; $display("FAIL ignore_lo got %h want %h", l, el); end
    exp_hi = eh; exp_lo = el;
  endtask

  task automatic test_mid_reset();
    bit sb, sd, sz;
    @(negedge clk);
    drive_start(F_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp += 4;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL midreset_done got %b want 0", done); end
    if (hi !== 32'h0) begin n_bad++; $display("FAIL midreset_hi got %h want 0", hi); end
    if (lo !== 32'h0) begin n_bad++; $display("FAIL midreset_lo got %h want 0", lo); end
    reset = 1'b0;
    observe_idle(40, sb, sd, sz);
    n_cmp += 2;
    if (sb) begin n_bad++; $display("FAIL midreset_after_busy got high want low"); end
    if (sd) begin n_bad++; $display("FAIL midreset_after_done got pulse want none"); end
    exp_hi = 32'h0; exp_lo = 32'h0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
`ifdef MULDIV_DIV_EN
    logic [5:0] fl [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    int nf = 4;
`else
    logic [5:0] fl [2] = '{F_MULT, F_MULTU};
    int nf = 2;
`endif
    int cyc; logic [31:0] a, b, h, l, eh, el; logic [5:0] f; logic dz, edz, bok;
    for (int i = 0; i < 30; i++) begin
      f = fl[$urandom_range(0, nf - 1)];
      a = pick_operand();
      b = pick_operand();
      ref_model(f, a, b, eh, el, edz);
      @(negedge clk);
      drive_start(f, a, b);
      wait_done(cyc, h, l, dz, bok);
      n_cmp += 4;
      if (cyc != LAT) begin n_bad++; $display("FAIL rnd%0d_latency got %0d want %0d", i, cyc, LAT); end
      if (h !== eh) begin n_bad++; $display("FAIL rnd%0d_hi f=%h a=%h b=%h got %h want %h", i, f, a, b, h, eh); end
      if (l !== el) begin n_bad++; $display("FAIL rnd%0d_lo f=%h a=%h b=%h got %h want %h", i, f, a, b, l, el); end
      if (dz !== edz) begin n_bad++; $display("FAIL rnd%0d_dz got %b want %b", i, dz, edz); end
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_div();
    test_divzero();
    test_illegal();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
